// File: rtl/hex_glyph_pkg.sv
// Glyph codes, active-low segment patterns and controller state type for the
// six-digit scrolling message display.
package hex_glyph_pkg;

    typedef enum logic [2:0] {
        GlyphSpace = 3'd0,
        GlyphG     = 3'd1,
        GlyphO     = 3'd2,
        GlyphB     = 3'd3,
        GlyphU     = 3'd4,
        GlyphF     = 3'd5,
        GlyphS     = 3'd6,
        GlyphRsvd  = 3'd7
    } glyph_e;

    localparam logic [7:0] SegSpace = 8'b11111111;
    localparam logic [7:0] SegG     = 8'b10001100;
    localparam logic [7:0] SegO     = 8'b10000001;
    localparam logic [7:0] SegB     = 8'b11100000;
    localparam logic [7:0] SegU     = 8'b11000001;
    localparam logic [7:0] SegF     = 8'b10111000;
    localparam logic [7:0] SegS     = 8'b10100100;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // The reserved code renders as a blank digit.
    function automatic logic [7:0] glyph_to_seg(input logic [2:0] code);
        case (glyph_e'(code))
            GlyphG:  return SegG;
            GlyphO:  return SegO;
            GlyphB:  return SegB;
            GlyphU:  return SegU;
            GlyphF:  return SegF;
            GlyphS:  return SegS;
            default: return SegSpace;
        endcase
    endfunction

endpackage

// File: rtl/hex_tick_gen.sv
// Scroll-rate prescaler: counts 0..TICK_DIV-1 while enabled and flags the
// last count so the controller can advance one window position.
module hex_tick_gen #(
    parameter int unsigned TICK_DIV = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic step_o
);

    localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);

    logic [15:0] tick_q, tick_d;

    always_comb begin
        tick_d = tick_q;
        if (clear_i) begin
            tick_d = '0;
        end else if (enable_i) begin
            tick_d = (tick_q == TickLast) ? '0 : tick_q + 16'd1;
        end
    end

    assign step_o = enable_i && (tick_q == TickLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolling message controller: a 16-glyph buffer loaded in IDLE, shown as a
// six-character window that steps and wraps across the message in RUN.
module hex_scroll_ctrl
    import hex_glyph_pkg::*;
#(
    parameter int unsigned TICK_DIV = 500,
    parameter int unsigned MAX_LEN  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en_i,
    input  logic [3:0] wr_addr_i,
    input  logic [2:0] wr_data_i,
    output logic       wr_ready_o,
    input  logic [4:0] msg_len_i,
    input  logic       start_i,
    input  logic       stop_i,
    output logic       busy_o,
    output logic       wrap_o,
    output logic [7:0] hex1_o,
    output logic [7:0] hex2_o,
    output logic [7:0] hex3_o,
    output logic [7:0] hex4_o,
    output logic [7:0] hex5_o,
    output logic [7:0] hex6_o
);

    localparam logic [4:0] MaxLen = 5'(MAX_LEN);

    state_e     state_q, state_d;
    logic [4:0] len_q, len_d;
    logic [4:0] pos_q, pos_d;
    logic       wrap_q, wrap_d;
    logic [2:0] msg_q [16];
    logic [2:0] msg_d [16];
    logic [7:0] hex_q [6];
    logic [7:0] hex_d [6];
    logic       step;
    logic       len_ok;

    // pos + offset never exceeds 20, so five conditional subtracts cover len = 1.
    function automatic logic [3:0] win_addr(input logic [4:0] base, input logic [2:0] off,
                                            input logic [4:0] len);
        logic [4:0] idx;
        idx = base + 5'(off);
        for (int i = 0; i < 5; i++) begin
            if (idx >= len) idx = idx - len;
        end
        return idx[3:0];
    endfunction

    hex_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (state_q == StRun),
        .clear_i  ((state_q == StIdle) || stop_i),
        .step_o   (step)
    );

    assign len_ok = (msg_len_i != 5'd0) && (msg_len_i <= MaxLen);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        msg_d   = msg_q;
        case (state_q)
            StIdle: begin
                if (wr_en_i) msg_d[wr_addr_i] = wr_data_i;
                if (start_i && !stop_i && len_ok) begin
                    state_d = StRun;
                    len_d   = msg_len_i;
                    pos_d   = '0;
                end
            end
            StRun: begin
                if (stop_i) begin
                    state_d = StIdle;
                    pos_d   = '0;
                end else if (step) begin
                    if (pos_q == len_q - 5'd1) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + 5'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Digits are decoded from next-state values so HEX changes on the same edge as pos.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            hex_d[k] = SegSpace;
            if (state_d == StRun) begin
                hex_d[k] = glyph_to_seg(msg_d[win_addr(pos_d, 3'(k), len_d)]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            len_q   <= 5'd1;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            for (int i = 0; i < 16; i++) msg_q[i] <= GlyphSpace;
            for (int k = 0; k < 6; k++) hex_q[k] <= SegSpace;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            msg_q   <= msg_d;
            hex_q   <= hex_d;
        end
    end

    assign busy_o     = (state_q == StRun);
    assign wr_ready_o = (state_q == StIdle);
    assign wrap_o     = wrap_q;
    assign hex1_o     = hex_q[0];
    assign hex2_o     = hex_q[1];
    assign hex3_o     = hex_q[2];
    assign hex4_o     = hex_q[3];
    assign hex5_o     = hex_q[4];
    assign hex6_o     = hex_q[5];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: directed scenarios plus random traffic, all
// checked every cycle against an arithmetic model of the scrolling display.
module tb_hex_scroll_ctrl;

    localparam int unsigned TickDiv = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [2:0] wr_data = '0;
    logic       wr_ready;
    logic [4:0] msg_len = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       busy;
    logic       wrap;
    logic [7:0] hex1, hex2, hex3, hex4, hex5, hex6;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int  m_mem [16];
    bit  m_run;
    int  m_len, m_pos, m_tick;
    bit  m_wrap;
    logic [7:0] seg_tab [8] = '{8'hFF, 8'h8C, 8'h81, 8'hE0, 8'hC1, 8'hB8, 8'hA4, 8'hFF};

    hex_scroll_ctrl #(
        .TICK_DIV (TickDiv),
        .MAX_LEN  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_ready_o (wr_ready),
        .msg_len_i  (msg_len),
        .start_i    (start),
        .stop_i     (stop),
        .busy_o     (busy),
        .wrap_o     (wrap),
        .hex1_o     (hex1),
        .hex2_o     (hex2),
        .hex3_o     (hex3),
        .hex4_o     (hex4),
        .hex5_o     (hex5),
        .hex6_o     (hex6)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [47:0] got_hex();
        return {hex1, hex2, hex3, hex4, hex5, hex6};
    endfunction

    function automatic logic [47:0] exp_hex();
        logic [47:0] r;
        for (int k = 0; k < 6; k++) begin
            r[47 - 8*k -: 8] = m_run ? seg_tab[m_mem[(m_pos + k) % m_len]] : 8'hFF;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_run  = 0;
        m_len  = 1;
        m_pos  = 0;
        m_tick = 0;
        m_wrap = 0;
    endtask

    task automatic model_step();
        m_wrap = 0;
        if (m_run) begin
            if (stop) begin
                m_run  = 0;
                m_pos  = 0;
                m_tick = 0;
            end else if (m_tick == TickDiv - 1) begin
                m_tick = 0;
                m_pos  = (m_pos + 1) % m_len;
                m_wrap = (m_pos == 0);
            end else begin
                m_tick++;
            end
        end else begin
            if (wr_en) m_mem[wr_addr] = int'(wr_data);
            if (start && !stop && msg_len >= 1 && msg_len <= 16) begin
                m_run  = 1;
                m_len  = int'(msg_len);
                m_pos  = 0;
                m_tick = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("hex", 64'(got_hex()), 64'(exp_hex()));
        check_eq("busy", 64'(busy), 64'(m_run));
        check_eq("wr_ready", 64'(wr_ready), 64'(!m_run));
        check_eq("wrap", 64'(wrap), 64'(m_wrap));
    endtask

    task automatic cycle();
        if (rst_n) model_step();
        else model_reset();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_write(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = 3'(d);
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        msg_len = 5'(len);
        cycle();
        start   = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    initial begin
        int msg [9] = '{1, 2, 0, 3, 4, 5, 5, 6, 0};
        int wraps;
        int wrap_at;

        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Illegal length is ignored
        do_start(0);
        check_eq("start_len0", 64'(busy), 64'd0);

        // "GO BUFFS " with nine glyphs
        for (int i = 0; i < 9; i++) do_write(i, msg[i]);
        do_start(9);
        check_eq("gobuffs_pos0", 64'(got_hex()), 64'h8C81FFE0C1B8);
        for (int i = 0; i < 4; i++) cycle();
        check_eq("gobuffs_pos1", 64'(got_hex()), 64'h81FFE0C1B8B8);
        wraps = 0;
        wrap_at = -1;
        for (int i = 5; i <= 40; i++) begin
            cycle();
            if (wrap) begin
                wraps++;
                if (wrap_at < 0) wrap_at = i;
                check_eq("wrap_hex", 64'(got_hex()), 64'h8C81FFE0C1B8);
            end
        end
        check_eq("wrap_count", 64'(wraps), 64'd1);
        check_eq("wrap_edge", 64'(wrap_at), 64'd36);

        // Write while running is dropped
        do_write(0, 6);
        do_stop();
        check_eq("stop_blank", 64'(got_hex()), 64'hFFFFFFFFFFFF);
        do_start(9);
        check_eq("slot0_kept", 64'(hex1), 64'h8C);
        do_stop();

        // start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        msg_len = 5'd9;
        cycle();
        start = 1'b0;
        stop = 1'b0;
        check_eq("start_stop_idle", 64'(busy), 64'd0);

        // stop on the tick = 3 cycle
        do_start(9);
        for (int i = 0; i < 3; i++) cycle();
        do_stop();
        check_eq("stop_tick3_busy", 64'(busy), 64'd0);
        check_eq("stop_tick3_wrap", 64'(wrap), 64'd0);

        // Length 2 "GO"
        do_start(2);
        check_eq("len2_pos0", 64'(got_hex()), 64'h8C818C818C81);
        for (int i = 0; i < 4; i++) cycle();
        check_eq("len2_pos1", 64'(got_hex()), 64'h818C818C818C);
        for (int i = 0; i < 4; i++) cycle();
        check_eq("len2_wrap", 64'(wrap), 64'd1);
        for (int i = 0; i < 3; i++) cycle();

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_hex", 64'(got_hex()), 64'hFFFFFFFFFFFF);
        check_eq("async_rst_busy", 64'(busy), 64'd0);
        #1;
        rst_n = 1'b1;
        do_start(16);
        check_eq("rst_buf_busy", 64'(busy), 64'd1);
        check_eq("rst_buf_hex", 64'(got_hex()), 64'hFFFFFFFFFFFF);
        for (int i = 0; i < 20; i++) cycle();
        do_stop();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, 9) < 4);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 3'($urandom_range(0, 7));
            start   = ($urandom_range(0, 14) == 0);
            stop    = ($urandom_range(0, 59) == 0);
            msg_len = 5'($urandom_range(0, 18));
            cycle();
        end
        wr_en = 1'b0;
        start = 1'b0;
        stop  = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hex_scroll_ctrl.md
# hex_scroll_ctrl

Scroll controller for the six-digit seven-segment message display. It holds a message of up to 16 glyph codes written through a simple write port, and steps a six-character window across the message at a fixed prescaled rate, wrapping around the end of the message. It drives the active-low segment buses HEX1..HEX6 directly, with HEX1 as the leftmost digit. It replaces hard-coded per-frame patterns with a loadable, start/stop-controlled sequencer.

## Interface
- TICK_DIV, 500: clk cycles per scroll step; legal range is 2..65535.
- MAX_LEN, 16: message buffer depth in glyphs; fixed at 16, so addresses are 4 bits.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- wr_en  in  1  write strobe for the message buffer.
- wr_addr  in  4  buffer slot to write.
- wr_data  in  3  glyph code to store.
- wr_ready  out  1  high in IDLE; a write takes effect only when wr_en & wr_ready.
- msg_len  in  5  message length; sampled on an accepted start; legal values 1..16.
- start  in  1  single-cycle request to begin scrolling.
- stop  in  1  single-cycle request to halt and blank the display.
- busy  out  1  high in RUN.
- wrap  out  1  one-cycle pulse when the window position returns to 0.
- HEX1..HEX6  out  8 each  active-low segment patterns; HEX1 is leftmost.

## Operation
- Glyph codes and their segment patterns:
  - 0 space = 8'b11111111
  - 1 G = 8'b10001100
  - 2 O = 8'b10000001
  - 3 B = 8'b11100000
  - 4 U = 8'b11000001
  - 5 F = 8'b10111000
  - 6 S = 8'b10100100
  - 7 is reserved and displays as space.
- State machine has two states, IDLE and RUN.
- IDLE:
  - HEX1..HEX6 = 8'hFF; busy = 0; wr_ready = 1.
  - Accepted write: buf[wr_addr] <= wr_data.
  - start with msg_len in 1..16 and stop low: latch len <= msg_len, pos <= 0, tick <= 0, go to RUN.
  - start with msg_len = 0 or > 16: ignored; remain in IDLE.
- RUN:
  - Digit k (k = 1..6) shows glyph buf[(pos + k - 1) mod len].
  - tick counts 0..TICK_DIV-1. On the cycle tick = TICK_DIV-1: tick <= 0 and pos <= (pos + 1) mod len.
  - If that step takes pos from len-1 to 0, wrap = 1 for exactly that cycle.
  - len < 6: the window repeats the message modulo len (e.g. len = 1 shows the same glyph on all six digits). With len = 1, wrap pulses every step.
  - Writes are ignored (wr_ready = 0). start is ignored.
  - stop: go to IDLE on the next edge; pos and tick clear; buffer contents are kept.
- start and stop asserted in the same cycle: stop wins. In IDLE, nothing happens.
- Modulo arithmetic is done in 5 bits: the sum pos + k - 1 is at most 20, with a single conditional subtract of len; for len < 6, up to 5 sequential subtracts, or a small lookup.

## Timing
- Reset values:
  - State IDLE, busy = 0, wr_ready = 1, wrap = 0.
  - HEX1..HEX6 = 8'hFF.
  - pos = 0, tick = 0, len = 1.
  - All 16 buffer slots = code 0 (space).
- Reset asserted mid-RUN: all of the above takes effect immediately (asynchronously). Operation resumes in IDLE from the first rising edge after rst_n deasserts.
- HEX outputs are registered, computed from next-state values:
  - Window pos 0 appears on the same edge that raises busy (the edge after the start cycle).
  - Each step updates HEX on the same edge as pos.
  - The first step occurs TICK_DIV edges after entry to RUN.
- wrap is registered and asserts on the same edge that HEX shows pos 0 again.
- stop latency: busy falls and HEX blanks on the edge after the stop cycle.
- An accepted write in IDLE is visible in the buffer on the next edge. Start latency is 1 cycle.

## Structure
- Package hex_glyph_pkg holds:
  - the glyph code enum (3 bits);
  - the segment pattern constants for space, G, O, B, U, F, S;
  - a function mapping glyph code to segments;
  - the IDLE/RUN state typedef.
- Sub-module hex_tick_gen is the prescaler:
  - inputs clk, rst_n, enable, clear;
  - output step, high on tick = TICK_DIV-1;
  - parameter TICK_DIV.
- Top level contains the FSM, the 16x3 buffer (flops), pos/len registers, window address math, and the six glyph decoders.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset release: HEX1..HEX6 = 8'hFF, busy = 0, wr_ready = 1, wrap = 0. Start with msg_len = 0 → busy stays 0.
- Load "GO BUFFS " (codes 1,2,0,3,4,5,5,6,0) into slots 0..8, start with msg_len = 9:
  - Edge after start: HEX1..HEX6 = 8C,81,FF,E0,C1,B8.
  - 4 edges later: 81,FF,E0,C1,B8,B8.
  - wrap pulses once, 36 edges after entry to RUN, with HEX back at the pos-0 pattern.
- While running, wr_en to slot 0 with code 6 is not applied (wr_ready = 0). After stop, the display blanks on the next edge and slot 0 still holds G.
- start and stop in the same IDLE cycle → busy stays 0. stop during RUN on the cycle tick = 3 → no step occurs, no wrap, IDLE next edge.
- Length 2, buffer "GO": HEX = 8C,81,8C,81,8C,81. After one step: 81,8C,81,8C,81,8C, and wrap fires on the second step.
- rst_n pulled low mid-RUN, between edges: HEX = 8'hFF and busy = 0 immediately. Buffer reads back all spaces after release.
